// File: rtl/iob_sram_responder_pkg.sv
// iob_sram_responder_pkg: shared FSM state encodings and width helpers for
// the iob SRAM responder. Benches import this to probe the FSM state.
package iob_sram_responder_pkg;

  localparam int BYTE_W     = 8;
  localparam int WAIT_CNT_W = 4;  // holds WAIT_STATES in 0..15

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACC  = 3'd2,
    ST_OREG = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Packed request width: {valid, addr, wdata, wstrb}
  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / BYTE_W;
  endfunction

  // Packed response width: {rdata, ready}
  function automatic int resp_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/iob_sram_responder_sp_be.sv
// iob_sram_sp_be: single-port SRAM with per-byte write enables, synchronous
// write and registered (read-first) read. Contents are never reset.
module iob_sram_sp_be #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                i_en,
  input  logic [DATA_W/8-1:0] i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_din,
  output logic [DATA_W-1:0]   o_dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
      logic [7:0] r_mem [0:(1<<ADDR_W)-1];
      logic [7:0] r_q;

      // One byte lane: optional write plus registered read of the old word
      always_ff @(posedge clk) begin
        if (i_en) begin
          if (i_we[gi]) begin
            r_mem[i_addr] <= i_din[gi*8 +: 8];
          end
          r_q <= r_mem[i_addr];
        end
      end

      assign o_dout[gi*8 +: 8] = r_q;
    end
  endgenerate

endmodule

// File: rtl/iob_sram_responder.sv
// iob_sram_responder: iob native bus responder serving reads and byte-masked
// writes from an internal word-addressed SRAM after WAIT_STATES wait cycles.
// Optional macro IOB_SRAM_RESP_OREG_EN adds an output register stage on
// {rdata, ready} (one extra FSM state, one extra cycle of latency).
// DATA_W must be 32: byte lanes are fixed at 4.
module iob_sram_responder
  import iob_sram_responder_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int MEM_ADDR_W  = 10,
  parameter  int WAIT_STATES = 1,
  localparam int REQ_W       = req_width(ADDR_W, DATA_W),
  localparam int RESP_W      = resp_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  req,
  output logic [RESP_W-1:0] resp
);

  localparam int STRB_W = DATA_W / BYTE_W;

  // Request bus fields
  logic              w_valid;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_wstrb;

  assign w_valid = req[REQ_W-1];
  assign w_addr  = req[REQ_W-2 -: ADDR_W];
  assign w_wdata = req[STRB_W +: DATA_W];
  assign w_wstrb = req[STRB_W-1:0];

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_accept;
  logic                  w_ram_en;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_ready;
  logic                  r_rd_valid;
  logic [DATA_W-1:0]     w_ram_dout;
  logic [DATA_W-1:0]     w_rdata;

  // Only the word index reaches the SRAM; the rest of the address aliases
  logic w_unused_addr;
  generate
    if (ADDR_W > MEM_ADDR_W + 2) begin : g_addr_hi
      assign w_unused_addr = ^{r_addr[ADDR_W-1:MEM_ADDR_W+2], r_addr[1:0]};
    end else begin : g_addr_nohi
      assign w_unused_addr = ^r_addr[1:0];
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, request acceptance and SRAM strobe
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_ram_en     = 1'b0;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_valid) begin
          w_accept     = 1'b1;
          w_state_next = (WAIT_STATES == 0) ? ST_ACC : ST_WAIT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_next = ST_ACC;
        end
      end
      ST_ACC: begin
        w_ram_en = 1'b1;
`ifdef IOB_SRAM_RESP_OREG_EN
        w_state_next = ST_OREG;
`else
        w_state_next = ST_RESP;
`endif
      end
      ST_OREG: begin
        w_state_next = ST_RESP;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Request latch, wait counter and response flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_ready    <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_wstrb <= w_wstrb;
        r_cnt   <= WAIT_CNT_W'(WAIT_STATES);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Both flags pulse for the single cycle after the ACC edge
      r_ready    <= (r_state == ST_ACC);
      r_rd_valid <= (r_state == ST_ACC) && (r_wstrb == '0);
    end
  end

  iob_sram_sp_be #(
    .ADDR_W (MEM_ADDR_W),
    .DATA_W (DATA_W)
  ) u_sram (
    .clk    (clk),
    .i_en   (w_ram_en),
    .i_we   (w_ram_en ? r_wstrb : '0),
    .i_addr (r_addr[MEM_ADDR_W+1:2]),
    .i_din  (r_wdata),
    .o_dout (w_ram_dout)
  );

  // The SRAM output register is the rdata register; it is forced to zero
  // for writes and whenever ready is low.
  assign w_rdata = r_rd_valid ? w_ram_dout : '0;

`ifdef IOB_SRAM_RESP_OREG_EN
  logic              r_oreg_ready;
  logic [DATA_W-1:0] r_oreg_rdata;

  // Output register stage on {rdata, ready}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_oreg_ready <= 1'b0;
      r_oreg_rdata <= '0;
    end else begin
      r_oreg_ready <= r_ready;
      r_oreg_rdata <= w_rdata;
    end
  end

  assign resp = {r_oreg_rdata, r_oreg_ready};
`else
  assign resp = {w_rdata, r_ready};
`endif

endmodule

// File: tb/tb_iob_sram_responder.sv
// tb_iob_sram_responder: randomized self-checking bench for the iob SRAM
// responder against a word-array reference model.
module tb_iob_sram_responder;
  import iob_sram_responder_pkg::*;

  localparam int WS     = 1;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int MAW    = 10;
  localparam int REQ_W  = 1 + AW + DW + DW/8;
  localparam int RESP_W = DW + 1;
  // Cycles from the cycle valid is presented to the cycle ready is high
`ifdef IOB_SRAM_RESP_OREG_EN
  localparam int LAT = WS + 3;
`else
  localparam int LAT = WS + 2;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [REQ_W-1:0]  req = '0;
  logic [RESP_W-1:0] resp;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } txn_t;

  txn_t        q[$];
  logic [31:0] model[int];
  logic        prev_ready = 1'b0;

  iob_sram_responder #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MEM_ADDR_W  (MAW),
    .WAIT_STATES (WS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .resp (resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Global response rules: ready never on two consecutive cycles, rdata 0 when idle
  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b0;
    end else begin
      chk("ready_twice", {31'b0, prev_ready & resp[0]}, 32'h0);
      if (!resp[0]) chk("rdata_idle", resp[DW:1], 32'h0);
      prev_ready = resp[0];
    end
  end

  // Reference: word memory indexed by addr bits [MAW+1:2]; writes return 0
  function automatic logic [31:0] model_access(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
    int          idx;
    logic [31:0] w;
    idx = int'((a >> 2) % (1 << MAW));
    if (s == 4'h0) return model.exists(idx) ? model[idx] : 32'hxxxx_xxxx;
    w = model.exists(idx) ? model[idx] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    model[idx] = w;
    return 32'h0;
  endfunction

  // Issue the queued transactions back-to-back; caller is at a negedge
  task automatic run(input string name);
    int          t0;
    logic [31:0] e;
    logic        got;
    t0 = cyc;
    for (int i = 0; i < q.size(); i++) begin
      if (i == 0) begin
        req = {1'b1, q[0].a, q[0].d, q[0].s};
        t0  = cyc;
      end
      e   = model_access(q[i].a, q[i].d, q[i].s);
      got = 1'b0;
      for (int n = 0; n < 64 && !got; n++) begin
        @(negedge clk);
        got = resp[0];
      end
      chk({name, "_timeout"}, {31'b0, got}, 32'h1);
      chk({name, "_rdata"}, resp[DW:1], e);
      chk({name, "_lat"}, 32'(cyc - t0), 32'(LAT));
      $display("txn %s #%0d addr=%h wdata=%h wstrb=%h rdata=%h lat=%0d",
               name, i, q[i].a, q[i].d, q[i].s, resp[DW:1], cyc - t0);
      if (i + 1 < q.size()) begin
        req = {1'b1, q[i+1].a, q[i+1].d, q[i+1].s};
        t0  = cyc;
      end else begin
        req = '0;
      end
    end
    q.delete();
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    txn_t t;
    t.a = a;
    t.d = d;
    t.s = s;
    q.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 3 cycles with a valid request on the bus
    req = {1'b1, 32'h10, 32'h1234_5678, 4'hF};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", {31'b0, resp[0]}, 32'h0);
      chk("rst_rdata", resp[DW:1], 32'h0);
    end
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

    // Full-word write then read
    push(32'h10, 32'hDEAD_BEEF, 4'hF);
    run("wr_full");
    push(32'h10, 32'h0, 4'h0);
    run("rd_full");

    // Byte mask
    push(32'h20, 32'h1122_3344, 4'hF);
    push(32'h22, 32'hAABB_CCDD, 4'h4);
    push(32'h20, 32'h0, 4'h0);
    run("bytemask");
    chk("bytemask_model", model[8], 32'h11BB_3344);

    // Wrap-around aliasing
    push(32'h0000_0004, 32'h5A5A_5A5A, 4'hF);
    push(32'h0000_1004, 32'h0, 4'h0);
    run("wrap");

    // Random back-to-back traffic on a small pre-initialized address set
    for (int k = 0; k < 8; k++) push(32'h100 + 32'(4*k), $urandom(), 4'hF);
    run("init");
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [3:0]  s;
      a = ($urandom() & 32'hFFFF_F000) | (32'h100 + 32'(4 * $urandom_range(0, 7)))
          | 32'($urandom_range(0, 3));
      s = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      push(a, $urandom(), s);
    end
    run("rand");

    // Eight back-to-back reads
    for (int k = 0; k < 8; k++) push(32'h100 + 32'(4*k), 32'h0, 4'h0);
    run("b2b");

    // Reset during WAIT drops the write
    push(32'h40, 32'h0BAD_F00D, 4'hF);
    run("pre_rst");
    req = {1'b1, 32'h40, 32'hCAFE_F00D, 4'hF};
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'b0, resp[0]}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_noresp", {31'b0, resp[0]}, 32'h0);
    end
    push(32'h40, 32'h0, 4'h0);
    run("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
